// File: rtl/serial_add_sequencer_if.sv
// Operand/result bundle for the nibble-serial adder: the requester drives
// operands and start, and the sequencer returns status and the registered result.
interface serial_add_sequencer_if #(
    parameter int NIB = 8
);
    logic                 start;
    logic                 sub;
    logic [4*NIB-1:0]     a;
    logic [4*NIB-1:0]     b;
    logic                 cin;
    logic                 busy;
    logic                 done;
    logic [4*NIB-1:0]     s;
    logic                 cout;
    logic                 ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Nibble-serial 32-bit add/subtract: one shared 4-bit CLA slice is stepped
// over NIB cycles, and the final result, carry and overflow are registered on completion.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module serial_add_sequencer #(
    parameter int NIB = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_sequencer_if.slave bus
);
    localparam int         W    = 4 * NIB;
    localparam logic [2:0] LAST = 3'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [2:0]     idx;
    logic           carry;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [W-1:0]   res;
    logic [W-1:0]   s_q;
    logic           cout_q;
    logic           ovf_q;
    logic [3:0]     slice_s;
    logic           slice_cout;
    logic           accept;
    logic           last;

    // Signed overflow: operands share a sign and the result's sign differs.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic r_msb);
        return ~(a_msb ^ b_msb) & (r_msb ^ a_msb);
    endfunction

    adder u_slice (
        .a    (opa[{idx, 2'b00} +: 4]),
        .b    (opb[{idx, 2'b00} +: 4]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx == LAST) state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = bus.start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so cin is replaced by the forced carry.
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
        end else if (state_q == RUN) begin
            res[{idx, 2'b00} +: 4] <= slice_s;
            carry                  <= slice_cout;
            idx                    <= idx + 3'd1;
            if (last) begin
                s_q    <= {slice_s, res[W-5:0]};
                cout_q <= slice_cout;
                ovf_q  <= ovf_f(opa[W-1], opb[W-1], slice_s[3]);
            end
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: latency, arithmetic corners,
// operand isolation during RUN, reset abort and back-to-back throughput.
module tb_serial_add_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_add_sequencer_if #(.NIB(8)) bus ();

    serial_add_sequencer #(.NIB(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin, input logic [31:0] es,
                          input logic ec, input logic eo);
        int busy_cnt;
        int guard;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cnt  = 0;
        guard     = 0;
        while (!bus.done && guard < 20) begin
            if (bus.busy) busy_cnt++;
            tick();
            guard++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: done=%b required 1", nm, bus.done);
        end
        checks++;
        if (busy_cnt !== 8) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d required 8", nm, busy_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_with_done: busy=%b required 0", nm, bus.busy);
        end
        checks++;
        if (bus.s !== es || bus.cout !== ec || bus.ovf !== eo) begin
            failures++;
            $display("FAIL %s_result: s=%h cout=%b ovf=%b required s=%h cout=%b ovf=%b",
                     nm, bus.s, bus.cout, bus.ovf, es, ec, eo);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.s !== es) begin
            failures++;
            $display("FAIL %s_pulse_hold: done=%b s=%h required done=0 s=%h",
                     nm, bus.done, bus.s, es);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 32'h0 ||
                bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: busy=%b done=%b s=%h cout=%b ovf=%b required all 0",
                         i, bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
            end
        end
    endtask

    task automatic test_add_sub();
        run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("sub_neg",  32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        // cin must be ignored for subtraction; 0x80000000 - 1 overflows.
        run_op("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("add_cin",  32'h0000000F, 32'h00000000, 1'b0, 1'b1, 32'h00000010, 1'b0, 1'b0);
    endtask

    task automatic test_isolation();
        int dones;
        bus.a     = 32'h0F0F0F0F;
        bus.b     = 32'h01010101;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.sub   = 1'($urandom_range(0, 1));
            bus.cin   = 1'($urandom_range(0, 1));
            bus.start = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.s !== 32'h10101010 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL isolation_result: done=%b s=%h cout=%b ovf=%b required done=1 s=10101010 cout=0 ovf=0",
                     bus.done, bus.s, bus.cout, bus.ovf);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL isolation_extra_done: got %0d extra pulses required 0", dones);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        bus.a     = 32'h00001234;
        bus.b     = 32'h00004321;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 32'h0 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b done=%b s=%h cout=%b ovf=%b required all 0",
                     bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_activity: got %0d busy/done cycles required 0", dones);
        end
        run_op("after_abort", 32'h00001234, 32'h00004321, 1'b0, 1'b0, 32'h00005555, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last_done;
        int pulses;
        bus.a     = 32'h12345678;
        bus.b     = 32'h11111111;
        bus.sub   = 1'b0;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        cyc       = 0;
        last_done = -1;
        pulses    = 0;
        while (pulses < 3 && cyc < 60) begin
            tick();
            cyc++;
            checks++;
            if (bus.busy && bus.done) begin
                failures++;
                $display("FAIL b2b_busy_and_done: cycle %0d both high", cyc);
            end
            if (bus.done) begin
                pulses++;
                checks++;
                if (bus.s !== 32'h2345678A || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: s=%h cout=%b ovf=%b required s=2345678a cout=0 ovf=0",
                             pulses, bus.s, bus.cout, bus.ovf);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done !== 9) begin
                        failures++;
                        $display("FAIL b2b_period: got %0d required 9", cyc - last_done);
                    end
                end
                last_done = cyc;
            end
        end
        checks++;
        if (pulses !== 3) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d required 3", pulses);
        end
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_sub();
        test_isolation();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter: NIB, default 8, number of 4-bit nibbles per operand; operand width W = 4*NIB; only NIB=8 (W=32) SHALL be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 Port: sub  input  1  0 = add, 1 = subtract (a - b); latched with start.
REQ-006 Port: a  input  32  operand A; latched with start.
REQ-007 Port: b  input  32  operand B; latched with start.
REQ-008 Port: cin  input  1  carry-in for add; ignored when sub=1; latched with start.
REQ-009 Port: busy  output  1  high while an operation is in progress (state RUN).
REQ-010 Port: done  output  1  one-cycle pulse when s/cout/ovf hold a new result.
REQ-011 Port: s  output  32  registered sum/difference.
REQ-012 Port: cout  output  1  registered carry-out of bit 31.
REQ-013 Port: ovf  output  1  registered two's-complement overflow flag.

Function
REQ-014 The block SHALL contain exactly one instance of the team's 4-bit CLA slice module adder (a[3:0], b[3:0], cin, s[3:0], cout) and SHALL compute the W-bit result by reusing it over NIB cycles.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-016 IDLE: start=1 -> RUN, with opA<=a, opB<=(sub ? ~b : b), carry<=(sub ? 1 : cin), nibble index idx<=0; start=0 -> stay IDLE.
REQ-017 RUN: each edge SHALL feed opA[4*idx+3:4*idx], opB[4*idx+3:4*idx], carry to the slice, store the slice sum into internal result nibble idx, set carry<=slice cout, idx<=idx+1.
REQ-018 RUN with idx=NIB-1: same as REQ-017, plus state<=DONE, s<=complete result, cout<=slice cout, ovf<=(opA[31] XNOR opB[31]) AND (result[31] XOR opA[31]).
REQ-019 Latency: done SHALL be high for exactly the one cycle following the 8th rising edge after the edge that accepted start; busy high for those 8 cycles only.
REQ-020 DONE: done=1, busy=0; start=1 -> accept per REQ-016 (back-to-back, 9-cycle throughput); start=0 -> IDLE.
REQ-021 start during RUN SHALL be ignored; a, b, sub, cin changes after acceptance SHALL NOT affect the running operation.
REQ-022 s, cout, ovf SHALL change only on the edge entering DONE (or on reset) and SHALL hold between operations.
REQ-023 idx SHALL be 3 bits; no wrap beyond NIB-1 occurs because RUN exits at idx=NIB-1.
REQ-024 done SHALL never be asserted in IDLE or RUN; busy and done SHALL never both be 1.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, idx=0, carry=0, opA=opB=0, s=0, cout=0, ovf=0, busy=0, done=0.
REQ-026 rst SHALL take priority over start; rst during RUN SHALL abort the operation with no done pulse and no output update.

Verification
REQ-027 Reset then idle 5 cycles, start=0 -> busy=0, done=0, s=0x00000000, cout=0, ovf=0 throughout.
REQ-028 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, start pulse -> busy high 8 cycles, then done 1 cycle, s=0x00000000, cout=1, ovf=0.
REQ-029 a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0; then a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> s=0x80000000, cout=0, ovf=1.
REQ-030 Start accepted; a/b/start toggled randomly during RUN -> result equals first-latched operands, exactly one done pulse.
REQ-031 Start accepted; rst at 4th RUN cycle -> no done, all outputs 0, next start computes correctly.
REQ-032 start held high continuously with a=0x12345678, b=0x11111111, cin=1 -> done every 9 cycles, s=0x2345678A, cout=0, ovf=0 each time.
